// File: rtl/audio_pwm_mixer.sv
// Three-voice gain/mute/saturate mixer feeding an 8-bit PWM headphone output.
// A one-entry hold buffer takes samples; a new level is loaded only on a PWM period boundary.
module audio_pwm_mixer #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned SAMPLE_W = 6,
    parameter int unsigned PWM_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*SAMPLE_W-1:0] ch_sample,
    input  logic [CHANNELS*2-1:0]        ch_gain,
    input  logic [CHANNELS-1:0]          ch_mute,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    output logic                         pwm,
    output logic                         period_start,
    output logic                         clip
);

    localparam int unsigned GAIN_W = 2;
    localparam int unsigned TERM_W = SAMPLE_W + 3;
    localparam int unsigned SUM_W  = TERM_W + $clog2(CHANNELS);
    localparam logic [SUM_W-1:0] LVL_MAX = SUM_W'((2 ** PWM_W) - 1);

    logic [PWM_W-1:0]             r_cnt;
    logic [PWM_W-1:0]             r_duty;
    logic                         r_clip;
    logic                         r_pwm;
    logic                         r_period_start;

    logic                         r_hold_full;
    logic [CHANNELS*SAMPLE_W-1:0] r_hold_sample;
    logic [CHANNELS*GAIN_W-1:0]   r_hold_gain;
    logic [CHANNELS-1:0]          r_hold_mute;

    logic                         r_mix_ok;
    logic [PWM_W-1:0]             r_mix_lvl;
    logic                         r_mix_sat;

    logic [TERM_W-1:0]            w_term [CHANNELS];
    logic [SUM_W-1:0]             w_sum;
    logic                         w_sat;
    logic                         w_wrap;
    logic                         w_accept;
    logic                         w_load;

    assign w_wrap       = (r_cnt == '1);
    assign w_accept     = sample_valid && !r_hold_full;
    // mix_ok implies hold_full, so a load never coincides with an accept
    assign w_load       = w_wrap && r_mix_ok;

    assign sample_ready = ~r_hold_full;
    assign pwm          = r_pwm;
    assign period_start = r_period_start;
    assign clip         = r_clip;

    // Full-width sum of shifted, muted terms; no intermediate truncation
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_term[i] = '0;
            if (!r_hold_mute[i]) begin
                w_term[i] = TERM_W'(r_hold_sample[i*SAMPLE_W +: SAMPLE_W])
                            << r_hold_gain[i*GAIN_W +: GAIN_W];
            end
            w_sum = w_sum + SUM_W'(w_term[i]);
        end
        w_sat = (w_sum > LVL_MAX);
    end

    // Free-running period counter and registered PWM output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + PWM_W'(1);
            r_pwm          <= (r_cnt < r_duty);
            r_period_start <= (r_cnt == '0);
        end
    end

    // One-entry hold buffer payload
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_sample <= '0;
            r_hold_gain   <= '0;
            r_hold_mute   <= '0;
        end else if (w_accept) begin
            r_hold_sample <= ch_sample;
            r_hold_gain   <= ch_gain;
            r_hold_mute   <= ch_mute;
        end
    end

    // Registered mix stage with saturation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mix_lvl <= '0;
            r_mix_sat <= 1'b0;
        end else begin
            r_mix_lvl <= w_sat ? LVL_MAX[PWM_W-1:0] : w_sum[PWM_W-1:0];
            r_mix_sat <= w_sat;
        end
    end

    // Buffer occupancy, mix validity and period-boundary duty load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_full <= 1'b0;
            r_mix_ok    <= 1'b0;
            r_duty      <= '0;
            r_clip      <= 1'b0;
        end else if (w_load) begin
            r_duty      <= r_mix_lvl;
            r_clip      <= r_mix_sat;
            r_hold_full <= 1'b0;
            r_mix_ok    <= 1'b0;
        end else begin
            r_mix_ok    <= r_hold_full;
            if (w_accept) begin
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule
